// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_arb_pkg : shared encodings for the data-memory arbiter.   Rev 1.0
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCK_D = 1'b1
  } arb_state_e;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam logic [31:0] DMEM_BASE_ADDR = 32'h8000_0000;

endpackage
`default_nettype wire

// File: rtl/dmem_addr_check.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_addr_check : window/alignment check and byte-to-word index.  Rev 1.0
// ---------------------------------------------------------------------------
module dmem_addr_check
  import dmem_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic [31:0]      i_addr,
  output logic             o_legal,
  output logic [IDX_W-1:0] o_idx
);

  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

  logic [31:0] w_off;

  // Range test on the offset avoids overflow of BASE_ADDR + window size.
  always_comb begin
    w_off   = i_addr - BASE_ADDR;
    o_legal = (i_addr >= BASE_ADDR) && ({1'b0, w_off} < SPAN) && (i_addr[1:0] == 2'b00);
    o_idx   = w_off[IDX_W+1:2];
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_arbiter : round-robin core/DMA arbiter for single-port dmem.  Rev 1.0
// ---------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          MAX_HOLD    = 8,
  parameter int          IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c_req,
  input  logic             c_we,
  input  logic [31:0]      c_addr,
  input  logic [31:0]      c_wdata,
  input  logic [3:0]       c_be,
  output logic             c_gnt,
  output logic             c_rvalid,
  output logic [31:0]      c_rdata,
  output logic             c_err,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wdata,
  input  logic [3:0]       d_be,
  input  logic             d_lock,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [31:0]      d_rdata,
  output logic             d_err,
  output logic             mem_en,
  output logic             mem_we,
  output logic [IDX_W-1:0] mem_idx,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_be,
  input  logic [31:0]      mem_rdata
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  arb_state_e        r_state;
  logic              r_ptr;
  logic [HOLD_W-1:0] r_hold;
  logic              r_c_rvalid, r_d_rvalid, r_rsp_err, r_rsp_load;

  logic              w_sel_c, w_sel_d, w_any, w_we, w_legal;
  logic              w_c_rvalid, w_d_rvalid;
  logic [31:0]       w_addr, w_wdata;
  logic [3:0]        w_be;
  logic [IDX_W-1:0]  w_idx;

  always_comb begin
    w_sel_c = 1'b0;
    w_sel_d = 1'b0;
    unique case (r_state)
      ARB: begin
        if (c_req && d_req) begin
          w_sel_c = (r_ptr == PORT_C);
          w_sel_d = (r_ptr == PORT_D);
        end else begin
          w_sel_c = c_req;
          w_sel_d = d_req;
        end
      end
      LOCK_D: begin
        // The hold limit lets a starving core through ahead of the locked DMA.
        if (c_req && (r_hold == HOLD_W'(MAX_HOLD))) w_sel_c = 1'b1;
        else if (d_req)                             w_sel_d = 1'b1;
        else                                        w_sel_c = c_req;
      end
      default: ;
    endcase
    if (rst) begin
      w_sel_c = 1'b0;
      w_sel_d = 1'b0;
    end
  end

  assign w_any   = w_sel_c | w_sel_d;
  assign w_addr  = w_sel_d ? d_addr  : c_addr;
  assign w_we    = w_sel_d ? d_we    : c_we;
  assign w_wdata = w_sel_d ? d_wdata : c_wdata;
  assign w_be    = w_sel_d ? d_be    : c_be;

  dmem_addr_check #(
    .BASE_ADDR   (BASE_ADDR),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_addr_check (
    .i_addr  (w_addr),
    .o_legal (w_legal),
    .o_idx   (w_idx)
  );

  assign c_gnt     = w_sel_c;
  assign d_gnt     = w_sel_d;
  assign mem_en    = w_any & w_legal;
  assign mem_we    = w_any & w_legal & w_we;
  assign mem_idx   = w_any ? w_idx   : '0;
  assign mem_wdata = w_any ? w_wdata : '0;
  assign mem_be    = w_any ? w_be    : 4'h0;

  // A reset landing on the response cycle drops that response.
  assign w_c_rvalid = r_c_rvalid & ~rst;
  assign w_d_rvalid = r_d_rvalid & ~rst;
  assign c_rvalid   = w_c_rvalid;
  assign d_rvalid   = w_d_rvalid;
  assign c_err      = w_c_rvalid & r_rsp_err;
  assign d_err      = w_d_rvalid & r_rsp_err;
  assign c_rdata    = (w_c_rvalid && r_rsp_load) ? mem_rdata : 32'h0;
  assign d_rdata    = (w_d_rvalid && r_rsp_load) ? mem_rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ARB;
      r_ptr      <= PORT_C;
      r_hold     <= '0;
      r_c_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_rsp_err  <= 1'b0;
      r_rsp_load <= 1'b0;
    end else begin
      r_c_rvalid <= w_sel_c;
      r_d_rvalid <= w_sel_d;
      r_rsp_err  <= w_any & ~w_legal;
      r_rsp_load <= w_any & w_legal & ~w_we;
      if (w_any) r_ptr <= w_sel_c ? PORT_D : PORT_C;
      unique case (r_state)
        ARB: begin
          if (w_sel_d && d_lock) begin
            r_state <= LOCK_D;
            r_hold  <= c_req ? HOLD_W'(1) : '0;
          end
        end
        LOCK_D: begin
          if (w_sel_c || !d_req || (w_sel_d && !d_lock)) begin
            r_state <= ARB;
            r_hold  <= '0;
          end else if (c_req) begin
            r_hold  <= r_hold + HOLD_W'(1);
          end else begin
            r_hold  <= '0;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_arbiter : vector table plus response scoreboard.          Rev 1.0
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          IDX_W = 10;
  localparam logic        H     = 1'b1;
  localparam logic        L     = 1'b0;
  localparam logic [31:0] Z32   = 32'h0;

  logic clk = 1'b0;
  logic rst;
  logic c_req, c_we, c_gnt, c_rvalid, c_err;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic [3:0]  c_be;
  logic d_req, d_we, d_lock, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic mem_en, mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_idx(mem_idx), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        c_req, c_we;
    logic [31:0] c_addr, c_wdata;
    logic        d_req, d_we, d_lock;
    logic [31:0] d_addr, d_wdata;
    logic        ec, ed, em;
  } vec_t;

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
    int          due;
  } rsp_t;

  vec_t        tbl[$];
  rsp_t        q[$];
  rsp_t        mon_e;
  logic [31:0] shadow [DEPTH];
  logic [31:0] mem [DEPTH];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [67:0] got_r, exp_r;

  function automatic logic [31:0] init_word(input int i);
    return (i == 1) ? 32'hFFFF_FFFF : 32'h1000_0000 + 32'(i);
  endfunction

  // Write-first synchronous single-port memory, preloaded on the first edge.
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_idx];
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    got_r = {c_rvalid, c_err, c_rdata, d_rvalid, d_err, d_rdata};
    if (q.size() > 0 && q[0].due == cyc) begin
      mon_e = q.pop_front();
      exp_r = {mon_e.port == PORT_C, (mon_e.port == PORT_C) && mon_e.err,
               (mon_e.port == PORT_C) ? mon_e.rdata : Z32,
               mon_e.port == PORT_D, (mon_e.port == PORT_D) && mon_e.err,
               (mon_e.port == PORT_D) ? mon_e.rdata : Z32};
      n_chk++;
      if (got_r !== exp_r) begin
        n_fail++;
        $display("FAIL response cyc=%0d: got {cv,ce,cd,dv,de,dd}=%h expected %h", cyc, got_r, exp_r);
      end
    end else if (c_rvalid || d_rvalid) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_rvalid cyc=%0d: got c_rvalid=%b d_rvalid=%b expected 0 0", cyc, c_rvalid, d_rvalid);
    end
  end

  function automatic vec_t mk(input logic cr, input logic cw, input logic [31:0] ca,
                              input logic [31:0] cd, input logic dr, input logic dw,
                              input logic dl, input logic [31:0] da, input logic [31:0] dd,
                              input logic ec, input logic ed, input logic em);
    vec_t v;
    v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
    v.d_req = dr; v.d_we = dw; v.d_lock = dl; v.d_addr = da; v.d_wdata = dd;
    v.ec = ec; v.ed = ed; v.em = em;
    return v;
  endfunction

  task automatic drive_idle();
    c_req = L; c_we = L; c_addr = Z32; c_wdata = Z32; c_be = 4'hF;
    d_req = L; d_we = L; d_lock = L; d_addr = Z32; d_wdata = Z32; d_be = 4'hF;
  endtask

  task automatic check_zero(input string name);
    n_chk++;
    if ({c_gnt, c_rvalid, c_err, c_rdata, d_gnt, d_rvalid, d_err, d_rdata,
         mem_en, mem_we, mem_idx, mem_wdata, mem_be} !== '0) begin
      n_fail++;
      $display("FAIL %s: got gnt=%b%b rvalid=%b%b err=%b%b mem_en=%b mem_we=%b idx=%h expected all 0",
               name, c_gnt, d_gnt, c_rvalid, d_rvalid, c_err, d_err, mem_en, mem_we, mem_idx);
    end
  endtask

  task automatic apply(input vec_t v, input logic push, input int n);
    logic [31:0]      a, wd;
    logic             we;
    logic [IDX_W-1:0] idx;
    rsp_t             e;
    @(posedge clk);
    #1;
    c_req = v.c_req; c_we = v.c_we; c_addr = v.c_addr; c_wdata = v.c_wdata;
    d_req = v.d_req; d_we = v.d_we; d_lock = v.d_lock; d_addr = v.d_addr; d_wdata = v.d_wdata;
    #3;
    n_chk++;
    if ({c_gnt, d_gnt, mem_en} !== {v.ec, v.ed, v.em}) begin
      n_fail++;
      $display("FAIL grant vec%0d: got c_gnt,d_gnt,mem_en=%b%b%b expected %b%b%b",
               n, c_gnt, d_gnt, mem_en, v.ec, v.ed, v.em);
    end
    if (v.ec || v.ed) begin
      a   = v.ec ? v.c_addr  : v.d_addr;
      we  = v.ec ? v.c_we    : v.d_we;
      wd  = v.ec ? v.c_wdata : v.d_wdata;
      idx = IDX_W'((a - BASE) >> 2);
      if (v.em) begin
        n_chk++;
        if ({mem_we, mem_idx, mem_be} !== {we, idx, 4'hF}) begin
          n_fail++;
          $display("FAIL mem_ctl vec%0d: got we=%b idx=%h be=%h expected we=%b idx=%h be=f",
                   n, mem_we, mem_idx, mem_be, we, idx);
        end
        if (we) begin
          n_chk++;
          if (mem_wdata !== wd) begin
            n_fail++;
            $display("FAIL mem_wdata vec%0d: got %h expected %h", n, mem_wdata, wd);
          end
        end
      end
      if (push) begin
        e.port  = v.ec ? PORT_C : PORT_D;
        e.err   = !v.em;
        e.rdata = (v.em && !we) ? shadow[idx] : Z32;
        if (v.em && we) shadow[idx] = wd;
        e.due   = cyc + 1;
        q.push_back(e);
      end
    end
  endtask

  initial begin
    vec_t idle, both, lk;
    rst = H;
    drive_idle();
    for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);

    idle = mk(L, L, Z32, Z32, L, L, L, Z32, Z32, L, L, L);
    both = mk(H, L, 32'h8000_0010, Z32, H, L, L, 32'h8000_0014, Z32, L, L, H);
    lk   = mk(H, L, 32'h8000_0020, Z32, H, L, H, 32'h8000_0040, Z32, L, H, H);
    tbl.push_back(mk(H, L, 32'h8000_0004, Z32, L, L, L, Z32, Z32, H, L, H));
    tbl.push_back(mk(L, L, Z32, Z32, H, L, L, 32'h8000_0000, Z32, L, H, H));
    for (int k = 0; k < 4; k++) begin
      both.ec = (k % 2 == 0); both.ed = (k % 2 == 1);
      tbl.push_back(both);
    end
    tbl.push_back(idle);
    tbl.push_back(mk(H, H, 32'h8000_0020, 32'hAAAA_5555, L, L, L, Z32, Z32, H, L, H));
    for (int k = 0; k < 8; k++) tbl.push_back(lk);
    lk.ec = H; lk.ed = L;
    tbl.push_back(lk);
    tbl.push_back(mk(H, L, 32'h8000_0020, Z32, H, L, L, 32'h8000_0040, Z32, L, H, H));
    tbl.push_back(mk(H, L, 32'h8000_0020, Z32, H, L, L, 32'h8000_0040, Z32, H, L, H));
    tbl.push_back(idle);
    tbl.push_back(mk(L, L, Z32, Z32, H, H, L, 32'h8000_0008, 32'h0000_0001, L, H, H));
    tbl.push_back(mk(H, L, 32'h8000_0008, Z32, L, L, L, Z32, Z32, H, L, H));
    tbl.push_back(mk(H, L, 32'h7FFF_FFFC, Z32, L, L, L, Z32, Z32, H, L, L));
    tbl.push_back(mk(H, L, 32'h8000_0002, Z32, L, L, L, Z32, Z32, H, L, L));
    tbl.push_back(mk(H, L, 32'h8000_1000, Z32, L, L, L, Z32, Z32, H, L, L));
    tbl.push_back(mk(H, L, 32'h8000_0FFC, Z32, L, L, L, Z32, Z32, H, L, H));
    tbl.push_back(idle);
    tbl.push_back(mk(L, L, Z32, Z32, H, L, H, 32'h8000_0044, Z32, L, H, H));
    tbl.push_back(idle);
    both.ec = H; both.ed = L;
    tbl.push_back(both);
    tbl.push_back(idle);

    repeat (2) @(posedge clk);
    #4 check_zero("reset_state");
    @(posedge clk);
    #1 rst = L;

    foreach (tbl[i]) apply(tbl[i], H, i);

    // Reset on the cycle after a locked DMA grant: response dropped, lock cleared.
    apply(mk(L, L, Z32, Z32, H, L, H, 32'h8000_0004, Z32, L, H, H), L, 100);
    @(posedge clk);
    #1;
    drive_idle();
    rst = H;
    #3 check_zero("mid_reset");
    @(posedge clk);
    #1 rst = L;
    apply(both, H, 101);
    apply(idle, H, 102);
    repeat (2) @(posedge clk);
    #4;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d responses outstanding expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the core load/store path (port C) and a DMA/preload engine (port D). The DMA engine writes test data and images into dmem while the core runs.
- Sits between processor_top's load/store logic, the DMA engine, and data_mem.
- Does round-robin arbitration with DMA burst lock and a hold limit.
- Checks the address window, translates byte addresses to word indices, and returns registered responses one cycle after grant.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of dmem word 0
- DEPTH_WORDS, 1024, dmem size in 32-bit words; power of two
- MAX_HOLD, 8, maximum consecutive DMA grants under lock while port C is waiting
- IDX_W, $clog2(DEPTH_WORDS), width of the word index

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- c_req  in  1  core request
- c_we  in  1  core write enable (1=store, 0=load)
- c_addr  in  32  core byte address
- c_wdata  in  32  core store data
- c_be  in  4  core byte enables
- c_gnt  out  1  core request accepted this cycle
- c_rvalid  out  1  core response valid
- c_rdata  out  32  core load data
- c_err  out  1  core response is an address error
- d_req, d_we, d_addr, d_wdata, d_be, d_gnt, d_rvalid, d_rdata, d_err  same as the core group, for DMA
- d_lock  in  1  DMA requests to keep ownership for its next access
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_idx  out  IDX_W  word index
- mem_wdata  out  32  write data
- mem_be  out  4  byte enables
- mem_rdata  in  32  synchronous read data, valid the cycle after mem_en

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values:
  - All gnt, rvalid, err, mem_en and mem_we are 0.
  - rdata, mem_idx, mem_wdata and mem_be are 0.
  - FSM is ARB. Priority pointer favours C. hold_cnt=0.
- FSM states:
  - ARB: normal round-robin.
  - LOCK_D: DMA owns the memory under lock.
- Grant rules:
  - Combinational gnt. At most one gnt per cycle.
  - A requester must hold req and its fields stable until gnt.
  - In ARB, only one requester → grant it.
  - In ARB, both requesting → grant the side the pointer favours. The pointer flips to the other side after every grant.
  - On a d_gnt with d_lock=1, go to LOCK_D.
- LOCK_D:
  - Grant D whenever d_req=1. hold_cnt increments per D grant while c_req=1, and resets when c_req=0.
  - If hold_cnt==MAX_HOLD and c_req=1, grant C this cycle, clear hold_cnt and return to ARB.
  - d_lock=0 on a D grant, or d_req=0 for one cycle, also returns to ARB.
  - In any state, a granted C request is never pre-empted.
- Address check:
  - Legal when addr>=BASE_ADDR, addr<BASE_ADDR+4*DEPTH_WORDS, and addr[1:0]==0.
  - mem_idx = (addr-BASE_ADDR)>>2, truncated to IDX_W.
  - Illegal granted access: gnt still asserts, mem_en=0, and the response has err=1 with rdata=0.
- Response:
  - The cycle after a grant, rvalid=1 on the granted port, writes included.
  - Loads return rdata=mem_rdata; stores return rdata=0.
  - Exactly one rvalid per gnt. Responses arrive in grant order.
  - Back-to-back grants give back-to-back rvalids.
- Write-then-read to the same index in consecutive cycles: the read returns the new data. The memory is write-first; the arbiter adds no bypass.
- Reset mid-operation: a response pending from the previous cycle is dropped (rvalid=0). The lock is cleared.

Decomposition:
- Shared package dmem_arb_pkg:
  - state encodings ARB/LOCK_D
  - port-select constants PORT_C=0 and PORT_D=1
  - BASE_ADDR default
- One sub-module, dmem_addr_check: combinational range/alignment check plus index computation, instantiated once on the muxed request.

Test Plan:
- Reset, then c_req load at 0x8000_0004 with dmem[1]=32'hFFFF_FFFF → c_gnt same cycle; next cycle c_rvalid=1, c_rdata=32'hFFFF_FFFF, c_err=0.
- c_req and d_req held high, no lock, 4 cycles → grants C,D,C,D; each rvalid lands on the matching port one cycle later.
- d_lock=1 with d_req continuous and c_req high from cycle 0 → 8 D grants, then c_gnt on the 9th; back in ARB.
- d_req store 32'h0000_0001 to 0x8000_0008 with be=4'hF, then c load of the same address next cycle → c_rdata=32'h0000_0001.
- c load at 0x7FFF_FFFC, then at 0x8000_0002 → gnt=1, mem_en=0; next cycle c_err=1, c_rdata=0 for each.
- rst pulsed the cycle after a d_gnt → d_rvalid stays 0, FSM is ARB, next simultaneous request grants C first.
